q_learning_sequencer: RTL and testbench

- Step controller for the Q-learning accelerator datapath (9 delay stages, action mux, 9-input max, Q updater).
- Accepts one learning step (state, action, next_state, reward) per handshake.
- Reads the Q-row of `state`, then the Q-row of `next_state`, from the action-row Q-table. It presents them to the datapath on consecutive cycles, so the delayed row feeds the action mux and the live row feeds max_Q.
- Writes the updated Q value back to the Q-table and pulses done.

---
 rtl/q_learning_sequencer_pkg.sv | 24 ++
 rtl/q_learning_sequencer_if.sv | 41 ++++
 rtl/q_learning_sequencer_sat_counter.sv | 20 ++
 rtl/q_learning_sequencer.sv | 109 ++++++++++
 tb/tb_q_learning_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/q_learning_sequencer_pkg.sv
// rtl/q_learning_sequencer_pkg.sv - shared types, widths and row helper for the Q-learning step sequencer
package q_learning_pkg;

   localparam int Q_W     = 16;
   localparam int N_ACT   = 9;
   localparam int STATE_W = 18;
   localparam int ROW_W   = N_ACT * Q_W;
   localparam logic [3:0] ACT_MAX = 4'd8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_S  = 3'd1,
      RD_NS = 3'd2,
      LOAD  = 3'd3,
      CALC  = 3'd4,
      WB    = 3'd5
   } seq_state_t;

   // Q value of action k inside a packed row (action k at bits [k*Q_W +: Q_W])
   function automatic logic [Q_W-1:0] row_q(input logic [ROW_W-1:0] row, input logic [3:0] k);
      return row[int'(k)*Q_W +: Q_W];
   endfunction

endpackage

// File: rtl/q_learning_sequencer_if.sv
// rtl/q_learning_sequencer_if.sv - request, Q-table and datapath signals of the step sequencer
interface q_learning_sequencer_if;
   import q_learning_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [STATE_W-1:0] req_state;
   logic [STATE_W-1:0] req_next_state;
   logic [3:0]         req_action;
   logic [7:0]         req_reward;

   logic               mem_rd_en;
   logic [STATE_W-1:0] mem_rd_addr;
   logic [ROW_W-1:0]   mem_rd_data;
   logic               mem_wr_en;
   logic [STATE_W-1:0] mem_wr_addr;
   logic [3:0]         mem_wr_action;
   logic [Q_W-1:0]     mem_wr_data;

   logic [ROW_W-1:0]   dp_data;
   logic [3:0]         dp_action;
   logic [7:0]         dp_reward;
   logic [Q_W-1:0]     dp_q_new;

   modport master (
      input  req_valid, req_state, req_next_state, req_action, req_reward,
      input  mem_rd_data, dp_q_new,
      output req_ready,
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_action, mem_wr_data,
      output dp_data, dp_action, dp_reward
   );

   modport slave (
      output req_valid, req_state, req_next_state, req_action, req_reward,
      output mem_rd_data, dp_q_new,
      input  req_ready,
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_action, mem_wr_data,
      input  dp_data, dp_action, dp_reward
   );

endinterface

// File: rtl/q_learning_sequencer_sat_counter.sv
// rtl/q_learning_sequencer_sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // count completed events, holding at the maximum instead of wrapping
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/q_learning_sequencer.sv
// rtl/q_learning_sequencer.sv - sequences one Q-learning step: two row reads, datapath feed, write-back
module q_learning_sequencer
   import q_learning_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   q_learning_sequencer_if.master bus,
   output logic                   done,
   output logic                   err,
   output logic                   busy,
   output logic [15:0]            step_count
);

   seq_state_t         state, next_state;
   logic [STATE_W-1:0] lat_s, lat_ns;
   logic               accept, legal;

   assign accept = (state == IDLE) && bus.req_valid;
   assign legal  = (bus.req_action <= ACT_MAX);

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // next state and per-state strobes/addresses
   always_comb begin
      next_state        = state;
      bus.req_ready     = 1'b0;
      bus.mem_rd_en     = 1'b0;
      bus.mem_rd_addr   = '0;
      bus.mem_wr_en     = 1'b0;
      bus.mem_wr_addr   = '0;
      bus.mem_wr_action = '0;
      done              = 1'b0;
      busy              = 1'b1;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
            if (accept && legal) next_state = RD_S;
         end
         RD_S: begin
            bus.mem_rd_en   = 1'b1;
            bus.mem_rd_addr = lat_s;
            next_state      = RD_NS;
         end
         RD_NS: begin
            bus.mem_rd_en   = 1'b1;
            bus.mem_rd_addr = lat_ns;
            next_state      = LOAD;
         end
         LOAD: next_state = CALC;
         CALC: next_state = WB;
         WB: begin
            bus.mem_wr_en     = 1'b1;
            bus.mem_wr_addr   = lat_s;
            bus.mem_wr_action = bus.dp_action;
            done              = 1'b1;
            next_state        = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // request latch, error pulse, row pipeline into the datapath and Q_new capture
   always_ff @(posedge clock) begin
      if (reset) begin
         lat_s           <= '0;
         lat_ns          <= '0;
         bus.dp_action   <= '0;
         bus.dp_reward   <= '0;
         bus.dp_data     <= '0;
         bus.mem_wr_data <= '0;
         err             <= 1'b0;
      end else begin
         err <= 1'b0;
         if (accept) begin
            if (legal) begin
               lat_s         <= bus.req_state;
               lat_ns        <= bus.req_next_state;
               bus.dp_action <= bus.req_action;
               bus.dp_reward <= bus.req_reward;
            end else begin
               err <= 1'b1;
            end
         end
         // row(s) arrives in RD_NS, row(s') in LOAD; each is shown for one cycle after
         if ((state == RD_NS) || (state == LOAD)) begin
            bus.dp_data <= bus.mem_rd_data;
         end
         if (state == CALC) begin
            bus.mem_wr_data <= bus.dp_q_new;
         end
      end
   end

   sat_counter #(.W(16)) u_step_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (state == WB),
      .count (step_count)
   );

endmodule

// File: tb/tb_q_learning_sequencer.sv
// tb/tb_q_learning_sequencer.sv - directed vector bench for the Q-learning step sequencer
module tb_q_learning_sequencer;
   import q_learning_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        done, err, busy;
   logic [15:0] step_count;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   q_learning_sequencer_if bus();

   q_learning_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .done       (done),
      .err        (err),
      .busy       (busy),
      .step_count (step_count)
   );

   // Q-table model: row 1 is flat 0x0100, row 5 descends from 0x0300, others encode address and action
   function automatic logic [ROW_W-1:0] mem_row(input logic [STATE_W-1:0] a);
      logic [ROW_W-1:0] r;
      for (int k = 0; k < N_ACT; k++) begin
         if (a == 18'h00001)      r[k*Q_W +: Q_W] = 16'h0100;
         else if (a == 18'h00005) r[k*Q_W +: Q_W] = 16'h0300 - 16'(k * 16);
         else                     r[k*Q_W +: Q_W] = {a[7:0], 4'h0, 4'(k)};
      end
      return r;
   endfunction

   always @(posedge clock) if (bus.mem_rd_en) bus.mem_rd_data <= mem_row(bus.mem_rd_addr);

   // datapath model: one delay stage, action mux on delayed row, max over live row
   logic [ROW_W-1:0] dly_row;
   logic [Q_W-1:0]   q_sa, q_max;
   always @(posedge clock) dly_row <= bus.dp_data;
   always_comb begin
      q_sa  = row_q(dly_row, bus.dp_action);
      q_max = row_q(bus.dp_data, 4'd0);
      for (int k = 1; k < N_ACT; k++)
         if (row_q(bus.dp_data, 4'(k)) > q_max) q_max = row_q(bus.dp_data, 4'(k));
      bus.dp_q_new = q_sa + ((q_max - q_sa) >> 1) + 16'(bus.dp_reward) + 16'd6;
   end

   typedef struct {
      int                 c;
      logic [STATE_W-1:0] addr;
      logic [3:0]         act;
      logic [Q_W-1:0]     data;
      logic               dn;
   } wr_rec_t;

   logic [STATE_W-1:0] rd_addr_q[$];
   int                 rd_cyc_q[$];
   wr_rec_t            wr_q[$];
   int                 done_q[$];
   int                 err_q[$];
   int                 overlap = 0;
   logic               ready_hist[int];
   logic [ROW_W-1:0]   dp_hist[int];

   always @(negedge clock) begin
      if (bus.mem_rd_en) begin
         rd_addr_q.push_back(bus.mem_rd_addr);
         rd_cyc_q.push_back(cyc);
      end
      if (bus.mem_wr_en) wr_q.push_back('{cyc, bus.mem_wr_addr, bus.mem_wr_action, bus.mem_wr_data, done});
      if (done) done_q.push_back(cyc);
      if (err) err_q.push_back(cyc);
      if (bus.mem_rd_en && bus.mem_wr_en) overlap++;
      ready_hist[cyc] = bus.req_ready;
      dp_hist[cyc]    = bus.dp_data;
   end

   task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      wr_q.delete();
      done_q.delete();
      err_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, 1);
      check({tag, "_strobes"}, {bus.mem_rd_en, bus.mem_wr_en, done, err, busy}, 0);
      check({tag, "_dp_data"}, bus.dp_data, 0);
      check({tag, "_dp_act_rew"}, {bus.dp_action, bus.dp_reward}, 0);
      check({tag, "_addrs"}, {bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_action}, 0);
      check({tag, "_wr_data"}, bus.mem_wr_data, 0);
      check({tag, "_step_count"}, step_count, 0);
   endtask

   // drive one request at a negedge in IDLE; returns the post-accept cycle number
   task automatic issue(input logic [17:0] s, input logic [17:0] ns, input logic [3:0] a,
                        input logic [7:0] r, output int acc);
      @(negedge clock);
      bus.req_state      = s;
      bus.req_next_state = ns;
      bus.req_action     = a;
      bus.req_reward     = r;
      bus.req_valid      = 1'b1;
      @(posedge clock);
      #1;
      acc = cyc;
      bus.req_valid = 1'b0;
   endtask

   typedef struct {
      logic [17:0] s;
      logic [17:0] ns;
      logic [3:0]  a;
      logic [7:0]  r;
      logic        exp_err;
      logic [15:0] exp_q;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc;
      int          acc3[3];
      int          w;
      logic [15:0] cnt0;
      vec_t        v;

      vecs[0] = '{18'h00001, 18'h00005, 4'd2, 8'd10,  1'b0, 16'h0210};
      vecs[1] = '{18'h00003, 18'h00004, 4'd9, 8'd1,   1'b1, 16'h0000};
      vecs[2] = '{18'h2AAAA, 18'h2AAAA, 4'd0, 8'd3,   1'b0, 16'hAA0D};
      vecs[3] = '{18'h00012, 18'h00034, 4'd8, 8'h20,  1'b0, 16'h232E};

      bus.req_valid = 1'b0;
      bus.req_state = '0;
      bus.req_next_state = '0;
      bus.req_action = '0;
      bus.req_reward = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_reset_vals("rst");

      // reset asserted during LOAD abandons the step
      clear_logs();
      issue(18'h00012, 18'h00034, 4'd8, 8'h20, acc);
      repeat (3) @(negedge clock);
      check("midrst_in_load_busy", busy, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_reset_vals("midrst");
      repeat (8) @(negedge clock);
      #1;
      check("midrst_no_write", wr_q.size(), 0);
      check("midrst_no_done", done_q.size(), 0);
      check("midrst_count", step_count, 0);

      // table-driven single steps
      for (int i = 0; i < 4; i++) begin
         v = vecs[i];
         clear_logs();
         cnt0 = step_count;
         issue(v.s, v.ns, v.a, v.r, acc);
         repeat (8) @(negedge clock);
         #1;
         if (v.exp_err) begin
            check($sformatf("v%0d_err_count", i), err_q.size(), 1);
            if (err_q.size() == 1) check($sformatf("v%0d_err_cycle", i), err_q[0], acc);
            check($sformatf("v%0d_no_rd_wr", i), {rd_addr_q.size(), wr_q.size()}, 0);
            check($sformatf("v%0d_ready_held", i),
                  {ready_hist[acc], ready_hist[acc+1], ready_hist[acc+2], ready_hist[acc+3]}, 4'hF);
            check($sformatf("v%0d_count", i), step_count, cnt0);
         end else begin
            check($sformatf("v%0d_rd_count", i), rd_addr_q.size(), 2);
            if (rd_addr_q.size() == 2) begin
               check($sformatf("v%0d_rd0", i), {rd_addr_q[0], 32'(rd_cyc_q[0])}, {v.s, 32'(acc)});
               check($sformatf("v%0d_rd1", i), {rd_addr_q[1], 32'(rd_cyc_q[1])}, {v.ns, 32'(acc + 1)});
            end
            check($sformatf("v%0d_dp_row_s", i), dp_hist[acc+2], mem_row(v.s));
            check($sformatf("v%0d_dp_row_ns", i), dp_hist[acc+3], mem_row(v.ns));
            check($sformatf("v%0d_wr_count", i), wr_q.size(), 1);
            if (wr_q.size() == 1) begin
               check($sformatf("v%0d_wr_cycle", i), wr_q[0].c, acc + 4);
               check($sformatf("v%0d_wr_fields", i), {wr_q[0].addr, wr_q[0].act, wr_q[0].data, wr_q[0].dn},
                     {v.s, v.a, v.exp_q, 1'b1});
            end
            check($sformatf("v%0d_done_count", i), done_q.size(), 1);
            check($sformatf("v%0d_no_err", i), err_q.size(), 0);
            check($sformatf("v%0d_dp_act_rew", i), {bus.dp_action, bus.dp_reward}, {v.a, v.r});
            check($sformatf("v%0d_count", i), step_count, cnt0 + 16'd1);
         end
      end
      check("after_vectors_count", step_count, 3);

      // back-to-back with req_valid held high
      clear_logs();
      @(negedge clock);
      bus.req_state = vecs[0].s; bus.req_next_state = vecs[0].ns;
      bus.req_action = vecs[0].a; bus.req_reward = vecs[0].r;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w = 0;
         while (!bus.req_ready && w < 20) begin
            @(negedge clock);
            w++;
         end
         check($sformatf("b2b_accept%0d_in_time", i), w < 20, 1);
         @(posedge clock);
         #1;
         acc3[i] = cyc;
         v = vecs[(i == 0) ? 3 : 2];
         bus.req_state = v.s; bus.req_next_state = v.ns;
         bus.req_action = v.a; bus.req_reward = v.r;
      end
      bus.req_valid = 1'b0;
      repeat (8) @(negedge clock);
      #1;
      check("b2b_wr_count", wr_q.size(), 3);
      if (wr_q.size() == 3) begin
         check("b2b_wr_spacing", {32'(wr_q[1].c - wr_q[0].c), 32'(wr_q[2].c - wr_q[1].c)}, {32'd6, 32'd6});
         check("b2b_wr0", {32'(wr_q[0].c), wr_q[0].addr, wr_q[0].data}, {32'(acc3[0] + 4), 18'h00001, 16'h0210});
         check("b2b_wr1", {wr_q[1].addr, wr_q[1].act, wr_q[1].data}, {18'h00012, 4'd8, 16'h232E});
         check("b2b_wr2", {wr_q[2].addr, wr_q[2].act, wr_q[2].data}, {18'h2AAAA, 4'd0, 16'hAA0D});
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("b2b_ready_low%0d", i),
               {ready_hist[acc3[i]], ready_hist[acc3[i]+1], ready_hist[acc3[i]+2],
                ready_hist[acc3[i]+3], ready_hist[acc3[i]+4]}, 0);
      end
      check("b2b_count", step_count, 6);
      check("rd_wr_never_overlap", overlap, 0);

      // saturation from a preloaded count
      @(negedge clock);
      force dut.u_step_cnt.count = 16'hFFFE;
      @(negedge clock);
      release dut.u_step_cnt.count;
      issue(vecs[3].s, vecs[3].ns, vecs[3].a, vecs[3].r, acc);
      repeat (8) @(negedge clock);
      #1;
      check("sat_first", step_count, 16'hFFFF);
      issue(vecs[0].s, vecs[0].ns, vecs[0].a, vecs[0].r, acc);
      repeat (8) @(negedge clock);
      #1;
      check("sat_hold", step_count, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
